hpdcache_fifo_reg_preload: RTL

Register-based FIFO whose contents, occupancy and pointers are preloaded to a parametrised fill level on reset and on a synchronous flush. Adds an occupancy counter, almost-full/almost-empty flags and an optional fall-through mode. Used as a restorable free-list or credit pool, for example MSHR or write-buffer index pools, where partial initial fill and runtime re-initialisation are required.

---
 rtl/hpdcache_fifo_reg_preload_pkg.sv | 23 ++
 rtl/hpdcache_fifo_reg_preload_chk.sv | 46 ++++
 rtl/hpdcache_fifo_wrap_ptr.sv | 51 +++++
 rtl/hpdcache_fifo_reg_preload.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/hpdcache_fifo_reg_preload_pkg.sv
// ----------------------------------------------------------------------------
// hpdcache_fifo_reg_preload_pkg
//   Helpers shared by the preloadable register FIFO and its pointer
//   sub-module.
//   Contents:
//     fifo_wrap_next : next value of a pointer that wraps at an arbitrary
//                      (not necessarily power-of-2) depth.
// ----------------------------------------------------------------------------
package hpdcache_fifo_reg_preload_pkg;

  // Modulo-depth increment without a divider: wrap to 0 after depth-1.
  function automatic logic [31:0] fifo_wrap_next(input logic [31:0] ptr,
                                                 input logic [31:0] depth);
    logic [31:0] nxt;
    if (ptr >= (depth - 32'd1)) begin
      nxt = 32'd0;
    end else begin
      nxt = ptr + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/hpdcache_fifo_reg_preload_chk.sv
// ----------------------------------------------------------------------------
// hpdcache_fifo_reg_preload_chk
//   Parameter sanity and state-consistency assertions for
//   hpdcache_fifo_reg_preload. Carries no functional logic.
//   Ports:
//     clk_i, rst_i : clock and synchronous reset of the FIFO
//     count_i      : occupancy register
//     rptr_i       : read pointer
//     wptr_i       : write pointer
// ----------------------------------------------------------------------------
module hpdcache_fifo_reg_preload_chk #(
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned INIT_COUNT       = FIFO_DEPTH,
  parameter int unsigned AFULL_THRESHOLD  = FIFO_DEPTH - 1,
  parameter int unsigned AEMPTY_THRESHOLD = 1,
  localparam int unsigned USAGE_W         = $clog2(FIFO_DEPTH + 1),
  localparam int unsigned PTR_W           = $clog2(FIFO_DEPTH)
) (
  input logic               clk_i,
  input logic               rst_i,
  input logic [USAGE_W-1:0] count_i,
  input logic [PTR_W-1:0]   rptr_i,
  input logic [PTR_W-1:0]   wptr_i
);

  logic [31:0] dist_s;
  logic [31:0] cnt_mod_s;

  // Pointer distance and occupancy, both reduced modulo the depth.
  always_comb begin
    dist_s    = (32'(wptr_i) + 32'(FIFO_DEPTH) - 32'(rptr_i)) % 32'(FIFO_DEPTH);
    cnt_mod_s = 32'(count_i) % 32'(FIFO_DEPTH);
  end

  // Parameter legality and occupancy/pointer coherence on every edge.
  always @(posedge clk_i) begin
    assert (FIFO_DEPTH >= 32'd2);
    assert (INIT_COUNT <= FIFO_DEPTH);
    assert ((AEMPTY_THRESHOLD < AFULL_THRESHOLD) && (AFULL_THRESHOLD <= FIFO_DEPTH));
    if (!rst_i) begin
      assert (32'(count_i) <= FIFO_DEPTH);
      assert (dist_s == cnt_mod_s);
    end
  end

endmodule

// File: rtl/hpdcache_fifo_wrap_ptr.sv
// ----------------------------------------------------------------------------
// hpdcache_fifo_wrap_ptr
//   Wrap-around pointer with synchronous load, used for the read and write
//   pointers of hpdcache_fifo_reg_preload.
//   Parameters:
//     DEPTH      : number of positions; pointer runs 0..DEPTH-1.
//     LOAD_VALUE : value taken when load_i is high.
//   Ports:
//     clk_i  in  clock
//     load_i in  synchronous load of LOAD_VALUE (priority over inc_i)
//     inc_i  in  advance by one, wrapping from DEPTH-1 to 0
//     ptr_o  out current pointer
// ----------------------------------------------------------------------------
module hpdcache_fifo_wrap_ptr
  import hpdcache_fifo_reg_preload_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned LOAD_VALUE = 0,
  localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             load_i,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  localparam logic [PTR_W-1:0] LOAD_PTR = PTR_W'(LOAD_VALUE);

  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] ptr_q;

  // Next pointer: load wins, otherwise wrap-increment on a transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = LOAD_PTR;
    end else if (inc_i) begin
      ptr_d = PTR_W'(fifo_wrap_next(32'(ptr_q), 32'(DEPTH)));
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register; reset arrives through load_i.
  always_ff @(posedge clk_i) begin
    ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/hpdcache_fifo_reg_preload.sv
// ----------------------------------------------------------------------------
// hpdcache_fifo_reg_preload
//   Register FIFO whose storage, pointers and occupancy are reloaded from
//   initial_value_i / INIT_COUNT on reset and on flush_i. Intended as a
//   restorable free-list or credit pool.
//   Ports:
//     clk_i, rst_i    clock, synchronous active-high reset
//     flush_i         synchronous re-initialisation (same effect as reset)
//     w_i/wok_o       write request / write accepted, wdata_i write data
//     r_i/rok_o       read request / read valid, rdata_o head entry
//     initial_value_i preload image, sampled only while rst_i or flush_i
//     usage_o         occupancy; full_o, empty_o, afull_o, aempty_o flags
// ----------------------------------------------------------------------------
module hpdcache_fifo_reg_preload
  import hpdcache_fifo_reg_preload_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter type         fifo_data_t      = logic,
  parameter int unsigned INIT_COUNT       = FIFO_DEPTH,
  parameter int unsigned AFULL_THRESHOLD  = FIFO_DEPTH - 1,
  parameter int unsigned AEMPTY_THRESHOLD = 1,
  parameter bit          FALL_THROUGH     = 1'b0,
  localparam int unsigned USAGE_W         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic                            w_i,
  output logic                            wok_o,
  input  fifo_data_t                      wdata_i,
  input  logic                            r_i,
  output logic                            rok_o,
  output fifo_data_t                      rdata_o,
  input  fifo_data_t [FIFO_DEPTH-1:0]     initial_value_i,
  output logic [USAGE_W-1:0]              usage_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic                            afull_o,
  output logic                            aempty_o
);

  localparam int unsigned      PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned      WPTR_INIT  = INIT_COUNT % FIFO_DEPTH;
  localparam logic [USAGE_W-1:0] INIT_USAGE = USAGE_W'(INIT_COUNT);
  localparam logic [USAGE_W-1:0] ONE        = USAGE_W'(32'd1);
  localparam logic INIT_FULL   = (INIT_COUNT == FIFO_DEPTH);
  localparam logic INIT_EMPTY  = (INIT_COUNT == 32'd0);
  localparam logic INIT_AFULL  = (INIT_COUNT >= AFULL_THRESHOLD);
  localparam logic INIT_AEMPTY = (INIT_COUNT <= AEMPTY_THRESHOLD);

  logic             init_s;
  logic             wok_s;
  logic             rok_s;
  logic             ft_fwd_s;
  logic             we_s;
  logic             re_s;
  logic             bypass_s;
  logic             push_s;
  logic             pop_s;
  fifo_data_t       rdata_s;
  logic [PTR_W-1:0] rptr_s;
  logic [PTR_W-1:0] wptr_s;

  logic [USAGE_W-1:0] count_d, count_q;
  logic               full_d, full_q;
  logic               empty_d, empty_q;
  logic               afull_d, afull_q;
  logic               aempty_d, aempty_q;
  fifo_data_t         mem_d [FIFO_DEPTH];
  fifo_data_t         mem_q [FIFO_DEPTH];

  assign init_s = rst_i | flush_i;

  // Handshake decode; the fall-through path serves an empty FIFO from wdata_i.
  always_comb begin
    ft_fwd_s = FALL_THROUGH & empty_q & w_i;
    wok_s    = ~full_q & ~init_s;
    rok_s    = ~init_s & (~empty_q | ft_fwd_s);
    we_s     = w_i & wok_s;
    re_s     = r_i & rok_s;
    // A same-cycle write and read on an empty fall-through FIFO never touches storage.
    bypass_s = FALL_THROUGH & empty_q & we_s & re_s;
    push_s   = we_s & ~bypass_s;
    pop_s    = re_s & ~bypass_s;
    if (ft_fwd_s) begin
      rdata_s = wdata_i;
    end else begin
      rdata_s = mem_q[rptr_s];
    end
  end

  // Storage, occupancy and flag next-state; flush reloads the preload image.
  always_comb begin
    mem_d = mem_q;
    if (flush_i) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_d[i] = initial_value_i[i];
      end
      count_d = INIT_USAGE;
    end else begin
      if (push_s) begin
        mem_d[wptr_s] = wdata_i;
      end else begin
        mem_d = mem_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end
    full_d   = (count_d == USAGE_W'(FIFO_DEPTH));
    empty_d  = (count_d == USAGE_W'(32'd0));
    afull_d  = (count_d >= USAGE_W'(AFULL_THRESHOLD));
    aempty_d = (count_d <= USAGE_W'(AEMPTY_THRESHOLD));
  end

  // State registers with synchronous reset to the preload state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= initial_value_i[i];
      end
      count_q  <= INIT_USAGE;
      full_q   <= INIT_FULL;
      empty_q  <= INIT_EMPTY;
      afull_q  <= INIT_AFULL;
      aempty_q <= INIT_AEMPTY;
    end else begin
      mem_q    <= mem_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  hpdcache_fifo_wrap_ptr #(
    .DEPTH      (FIFO_DEPTH),
    .LOAD_VALUE (32'd0)
  ) u_rptr (
    .clk_i  (clk_i),
    .load_i (init_s),
    .inc_i  (pop_s),
    .ptr_o  (rptr_s)
  );

  hpdcache_fifo_wrap_ptr #(
    .DEPTH      (FIFO_DEPTH),
    .LOAD_VALUE (WPTR_INIT)
  ) u_wptr (
    .clk_i  (clk_i),
    .load_i (init_s),
    .inc_i  (push_s),
    .ptr_o  (wptr_s)
  );

  hpdcache_fifo_reg_preload_chk #(
    .FIFO_DEPTH       (FIFO_DEPTH),
    .INIT_COUNT       (INIT_COUNT),
    .AFULL_THRESHOLD  (AFULL_THRESHOLD),
    .AEMPTY_THRESHOLD (AEMPTY_THRESHOLD)
  ) u_chk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .count_i (count_q),
    .rptr_i  (rptr_s),
    .wptr_i  (wptr_s)
  );

  assign wok_o    = wok_s;
  assign rok_o    = rok_s;
  assign rdata_o  = rdata_s;
  assign usage_o  = count_q;
  assign full_o   = full_q;
  assign empty_o  = empty_q;
  assign afull_o  = afull_q;
  assign aempty_o = aempty_q;

endmodule
